bus_nxm: RTL and testbench
==========================

// Module: bus_nxm
// PURPOSE
//  Parametrised shared bus: N_MASTERS masters, N_SLAVES slaves, one owner at a time.
//  Round-robin arbiter with ownership lock; muxes owner's wr/address/dout to slaves.
//  Decodes the slave from the top address bits; flags unmapped accesses.
//  Returns registered slave read data to the masters.
//  Next generation of the fixed 2-master/2-slave system bus; drops in at the same level.
// PARAMETERS
//  N_MASTERS  2   number of masters, 2..8
//  N_SLAVES   2   number of slaves, 1..2**SEL_BITS
//  AW         8   address width
//  DW         32  data width
//  SEL_BITS   1   top address bits used as slave index, SEL_BITS < AW
// PORTS
//  clk        in   1            system clock, rising edge
//  reset_n    in   1            asynchronous active-low reset
//  m_req      in   N_MASTERS    per-master bus request
//  m_wr       in   N_MASTERS    per-master write enable
//  m_address  in   N_MASTERS*AW master i at [i*AW +: AW]
//  m_dout     in   N_MASTERS*DW master i write data at [i*DW +: DW]
//  s_dout     in   N_SLAVES*DW  slave j read data at [j*DW +: DW]
//  m_grant    out  N_MASTERS    one-hot grant, registered
//  m_din      out  DW           read data to all masters
//  m_err      out  1            unmapped-access flag, registered
//  s_sel      out  N_SLAVES     one-hot slave select, combinational
//  s_address  out  AW           owner's address
//  s_wr       out  1            owner's write enable
//  s_din      out  DW           owner's write data
// BEHAVIOUR
//  Reset: m_grant=1 (master 0 parked), rd_sel_q=0, m_err=0.
//   m_din=0 until the first decoded access.
//  Arbiter: owner register (one-hot m_grant); updates only on clk.
//   - Owner's m_req=1: grant held (lock), regardless of other requests.
//   - Owner's m_req=0, others requesting: next cycle grant the first requester.
//     Scan order is owner+1, owner+2, ... mod N_MASTERS (round-robin).
//   - No requests: next cycle grant parks on master 0.
//   - Grant reaches a requester at most N_MASTERS-1 handovers after it asserts m_req.
//  Datapath (combinational from m_grant):
//   - s_wr/s_address/s_din = the owner's fields.
//   - Forwarded whether or not the owner requests; slaves qualify with s_sel.
//  Decode: idx = s_address[AW-1 -: SEL_BITS].
//   - Valid only when the owner's m_req=1.
//   - idx < N_SLAVES: s_sel[idx]=1.
//   - idx >= N_SLAVES (unmapped): s_sel=0.
//   - Owner's m_req=0: s_sel=0.
//  Read return, 1-cycle latency:
//   - rd_sel_q <= s_sel each clk.
//   - m_din = s_dout of the slave flagged in rd_sel_q; 0 if rd_sel_q==0.
//  m_err <= owner's m_req & unmapped idx; a 1-cycle pulse per cycle of unmapped access.
//  Async reset mid-transfer: grant immediately returns to master 0; rd_sel_q/m_err clear.
// TESTING
//  1. Reset, no requests -> m_grant=2'b01, s_sel=0, m_din=0, m_err=0.
//  2. m_req=01, m0_address=8'h05, s0_dout=32'hA5A5A5A5.
//     -> s_sel=01 same cycle; m_din=A5A5A5A5 one cycle later.
//  3. m_req=11 with master 0 owning; drop m_req[0].
//     -> next cycle m_grant=10, s_address=m1_address.
//  4. N_MASTERS=4, all requesting, each owner drops req for 1 cycle after 2 cycles.
//     -> grant order 0,1,2,3,0.
//  5. N_SLAVES=3, SEL_BITS=2, address 8'hC0.
//     -> s_sel=000; m_err=1 next cycle; m_din=0 next cycle.
//  6. Assert reset_n=0 while m_grant=10 mid-write.
//     -> m_grant=01, m_err=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/bus_nxm.sv
// Shared N-master / M-slave bus: round-robin arbiter with ownership lock, address
// decode to a one-hot slave select, and registered read-data return to the masters.
module bus_nxm #(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 2,
    parameter int AW        = 8,
    parameter int DW        = 32,
    parameter int SEL_BITS  = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_MASTERS-1:0]    m_req,
    input  logic [N_MASTERS-1:0]    m_wr,
    input  logic [N_MASTERS*AW-1:0] m_address,
    input  logic [N_MASTERS*DW-1:0] m_dout,
    input  logic [N_SLAVES*DW-1:0]  s_dout,
    output logic [N_MASTERS-1:0]    m_grant,
    output logic [DW-1:0]           m_din,
    output logic                    m_err,
    output logic [N_SLAVES-1:0]     s_sel,
    output logic [AW-1:0]           s_address,
    output logic                    s_wr,
    output logic [DW-1:0]           s_din
);

    localparam int OW = $clog2(N_MASTERS);

    logic [N_MASTERS-1:0] r_grant;
    logic [N_MASTERS-1:0] w_grant_next;
    logic [N_SLAVES-1:0]  r_rd_sel;
    logic                 r_err;
    logic [OW-1:0]        w_owner;
    logic                 w_owner_req;
    logic                 w_mapped;
    logic [SEL_BITS-1:0]  w_idx;
    logic [OW:0]          w_cand_sum;
    logic [OW-1:0]        w_cand;
    logic                 w_found;
    logic [AW-1:0]        w_m_addr  [N_MASTERS];
    logic [DW-1:0]        w_m_dout  [N_MASTERS];
    logic [DW-1:0]        w_s_dout  [N_SLAVES];
    logic [DW-1:0]        w_din_acc [N_SLAVES+1];

    genvar gi;
    generate
        for (gi = 0; gi < N_MASTERS; gi++) begin : g_master
            assign w_m_addr[gi] = m_address[gi*AW +: AW];
            assign w_m_dout[gi] = m_dout[gi*DW +: DW];
        end
        // Slave select and the AND-OR read-return mux share one loop over slaves
        for (gi = 0; gi < N_SLAVES; gi++) begin : g_slave
            assign w_s_dout[gi]    = s_dout[gi*DW +: DW];
            assign s_sel[gi]       = w_owner_req && (w_idx == SEL_BITS'(gi));
            assign w_din_acc[gi+1] = w_din_acc[gi] | (r_rd_sel[gi] ? w_s_dout[gi] : '0);
        end
    endgenerate

    assign w_din_acc[0] = '0;

    always_comb begin
        w_owner = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (r_grant[i]) w_owner = OW'(i);
        end
    end

    assign w_owner_req = |(m_req & r_grant);
    assign w_idx       = s_address[AW-1 -: SEL_BITS];
    assign w_mapped    = ({1'b0, w_idx} < (SEL_BITS+1)'(N_SLAVES));

    // State register: the one-hot owner parks on master 0 after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant  <= N_MASTERS'(1);
            r_rd_sel <= '0;
            r_err    <= 1'b0;
        end else begin
            r_grant  <= w_grant_next;
            r_rd_sel <= s_sel;
            r_err    <= w_owner_req & ~w_mapped;
        end
    end

    // Next owner: hold while the owner requests, else first requester after it, else park
    always_comb begin
        w_grant_next = N_MASTERS'(1);
        w_found      = 1'b0;
        w_cand_sum   = '0;
        w_cand       = '0;
        if (w_owner_req) begin
            w_grant_next = r_grant;
        end else begin
            for (int k = 1; k < N_MASTERS; k++) begin
                w_cand_sum = {1'b0, w_owner} + (OW+1)'(k);
                if (w_cand_sum >= (OW+1)'(N_MASTERS))
                    w_cand_sum = w_cand_sum - (OW+1)'(N_MASTERS);
                w_cand = w_cand_sum[OW-1:0];
                if (!w_found && m_req[w_cand]) begin
                    w_grant_next         = '0;
                    w_grant_next[w_cand] = 1'b1;
                    w_found              = 1'b1;
                end
            end
        end
    end

    always_comb begin
        s_address = w_m_addr[w_owner];
        s_din     = w_m_dout[w_owner];
        s_wr      = m_wr[w_owner];
    end

    assign m_grant = r_grant;
    assign m_err   = r_err;
    assign m_din   = w_din_acc[N_SLAVES];

endmodule

// File: tb/tb_bus_nxm.sv
// Directed bench for bus_nxm: a 2x2 instance driven from a vector table, plus a
// 4-master instance for round-robin order and a 3-slave instance for unmapped decode.
module tb_bus_nxm;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // 2 masters, 2 slaves
    logic [1:0]  req2 = '0, wr2 = '0;
    logic [15:0] addr2 = '0;
    logic [63:0] mdout2 = {32'h22222222, 32'h11111111};
    logic [63:0] sdout2 = {32'h5A5A5A5A, 32'hA5A5A5A5};
    logic [1:0]  grant2, sel2;
    logic [31:0] mdin2, sdin2;
    logic        err2, swr2;
    logic [7:0]  saddr2;

    // 4 masters, 2 slaves
    logic [3:0]   req4 = '0, wr4 = '0;
    logic [31:0]  addr4 = '0;
    logic [127:0] mdout4 = '0;
    logic [63:0]  sdout4 = '0;
    logic [3:0]   grant4;
    logic [1:0]   sel4;
    logic [31:0]  mdin4, sdin4;
    logic         err4, swr4;
    logic [7:0]   saddr4;

    // 2 masters, 3 slaves, 2 select bits
    logic [1:0]  req3 = '0, wr3 = '0;
    logic [15:0] addr3 = '0;
    logic [63:0] mdout3 = '0;
    logic [95:0] sdout3 = {32'h33333333, 32'h22222222, 32'h11111111};
    logic [1:0]  grant3;
    logic [2:0]  sel3;
    logic [31:0] mdin3, sdin3;
    logic        err3, swr3;
    logic [7:0]  saddr3;

    bus_nxm u_dut2 (
        .clk(clk), .reset_n(rst_n), .m_req(req2), .m_wr(wr2), .m_address(addr2),
        .m_dout(mdout2), .s_dout(sdout2), .m_grant(grant2), .m_din(mdin2), .m_err(err2),
        .s_sel(sel2), .s_address(saddr2), .s_wr(swr2), .s_din(sdin2)
    );

    bus_nxm #(.N_MASTERS(4)) u_dut4 (
        .clk(clk), .reset_n(rst_n), .m_req(req4), .m_wr(wr4), .m_address(addr4),
        .m_dout(mdout4), .s_dout(sdout4), .m_grant(grant4), .m_din(mdin4), .m_err(err4),
        .s_sel(sel4), .s_address(saddr4), .s_wr(swr4), .s_din(sdin4)
    );

    bus_nxm #(.N_SLAVES(3), .SEL_BITS(2)) u_dut3 (
        .clk(clk), .reset_n(rst_n), .m_req(req3), .m_wr(wr3), .m_address(addr3),
        .m_dout(mdout3), .s_dout(sdout3), .m_grant(grant3), .m_din(mdin3), .m_err(err3),
        .s_sel(sel3), .s_address(saddr3), .s_wr(swr3), .s_din(sdin3)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  wr;
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [1:0]  e_grant;
        logic [1:0]  e_sel;
        logic [7:0]  e_addr;
        logic        e_wr;
        logic [31:0] e_sdin;
        logic [31:0] e_mdin;
        logic        e_err;
    } vec_t;

    vec_t vecs[14];

    initial begin
        // Inputs applied at the falling edge; every field checked 1 time unit later.
        // Registered outputs reflect the vectors before the current one.
        vecs[0]  = '{2'b00, 2'b00, 8'h05, 8'h85, 2'b01, 2'b00, 8'h05, 1'b0, 32'h11111111, 32'h00000000, 1'b0};
        vecs[1]  = '{2'b01, 2'b00, 8'h05, 8'h85, 2'b01, 2'b01, 8'h05, 1'b0, 32'h11111111, 32'h00000000, 1'b0};
        vecs[2]  = '{2'b01, 2'b00, 8'h05, 8'h85, 2'b01, 2'b01, 8'h05, 1'b0, 32'h11111111, 32'hA5A5A5A5, 1'b0};
        vecs[3]  = '{2'b11, 2'b01, 8'h05, 8'h85, 2'b01, 2'b01, 8'h05, 1'b1, 32'h11111111, 32'hA5A5A5A5, 1'b0};
        vecs[4]  = '{2'b10, 2'b00, 8'h05, 8'h85, 2'b01, 2'b00, 8'h05, 1'b0, 32'h11111111, 32'hA5A5A5A5, 1'b0};
        vecs[5]  = '{2'b10, 2'b10, 8'h05, 8'h85, 2'b10, 2'b10, 8'h85, 1'b1, 32'h22222222, 32'h00000000, 1'b0};
        vecs[6]  = '{2'b10, 2'b00, 8'h05, 8'h85, 2'b10, 2'b10, 8'h85, 1'b0, 32'h22222222, 32'h5A5A5A5A, 1'b0};
        vecs[7]  = '{2'b11, 2'b01, 8'h05, 8'h85, 2'b10, 2'b10, 8'h85, 1'b0, 32'h22222222, 32'h5A5A5A5A, 1'b0};
        vecs[8]  = '{2'b01, 2'b00, 8'h05, 8'h85, 2'b10, 2'b00, 8'h85, 1'b0, 32'h22222222, 32'h5A5A5A5A, 1'b0};
        vecs[9]  = '{2'b00, 2'b00, 8'h05, 8'h85, 2'b01, 2'b00, 8'h05, 1'b0, 32'h11111111, 32'h00000000, 1'b0};
        vecs[10] = '{2'b10, 2'b00, 8'h05, 8'h85, 2'b01, 2'b00, 8'h05, 1'b0, 32'h11111111, 32'h00000000, 1'b0};
        vecs[11] = '{2'b00, 2'b00, 8'h05, 8'h85, 2'b10, 2'b00, 8'h85, 1'b0, 32'h22222222, 32'h00000000, 1'b0};
        vecs[12] = '{2'b01, 2'b00, 8'h85, 8'h85, 2'b01, 2'b10, 8'h85, 1'b0, 32'h11111111, 32'h00000000, 1'b0};
        vecs[13] = '{2'b00, 2'b00, 8'h85, 8'h85, 2'b01, 2'b00, 8'h85, 1'b0, 32'h11111111, 32'h5A5A5A5A, 1'b0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 2x2 table
        for (int v = 0; v < 14; v++) begin
            @(negedge clk);
            req2  = vecs[v].req;
            wr2   = vecs[v].wr;
            addr2 = {vecs[v].a1, vecs[v].a0};
            #1;
            $display("vec %0d: req=%b grant=%b sel=%b addr=%h din=%h err=%b",
                     v, req2, grant2, sel2, saddr2, mdin2, err2);
            check($sformatf("v%0d_grant", v), grant2, vecs[v].e_grant);
            check($sformatf("v%0d_sel", v),   sel2,   vecs[v].e_sel);
            check($sformatf("v%0d_saddr", v), saddr2, vecs[v].e_addr);
            check($sformatf("v%0d_swr", v),   swr2,   vecs[v].e_wr);
            check($sformatf("v%0d_sdin", v),  sdin2,  vecs[v].e_sdin);
            check($sformatf("v%0d_mdin", v),  mdin2,  vecs[v].e_mdin);
            check($sformatf("v%0d_err", v),   err2,   vecs[v].e_err);
        end
        req2 = '0;
        wr2  = '0;

        // 4 masters, all requesting, each owner drops its request once: order 0,1,2,3,0
        @(negedge clk);
        req4 = 4'hF;
        #1;
        check("rr_start", grant4, 4'b0001);
        for (int step = 0; step < 4; step++) begin
            logic [3:0] exp_own;
            logic [3:0] exp_next;
            exp_own  = 4'b0001 << step;
            exp_next = 4'b0001 << ((step + 1) % 4);
            repeat (2) begin
                @(negedge clk);
                #1;
                check($sformatf("rr_hold%0d", step), grant4, exp_own);
            end
            @(negedge clk);
            req4[step] = 1'b0;
            @(negedge clk);
            req4 = 4'hF;
            #1;
            $display("rr step %0d: grant=%b", step, grant4);
            check($sformatf("rr_next%0d", step), grant4, exp_next);
        end
        // Round-robin scan starts after the owner, not at master 0
        @(negedge clk);
        req4 = 4'b1100;
        @(negedge clk);
        #1;
        check("rr_skip_to2", grant4, 4'b0100);
        req4 = 4'b0011;
        @(negedge clk);
        #1;
        check("rr_wrap_to0", grant4, 4'b0001);
        req4 = 4'b0010;
        @(negedge clk);
        #1;
        check("rr_to1", grant4, 4'b0010);
        req4 = 4'b0000;
        @(negedge clk);
        #1;
        $display("rr park: grant=%b", grant4);
        check("rr_park", grant4, 4'b0001);

        // 3 slaves with 2 select bits: index 2 mapped, index 3 unmapped
        @(negedge clk);
        req3 = 2'b01;
        addr3[7:0] = 8'h80;
        #1;
        check("dec_grant", grant3, 2'b01);
        check("dec_sel_map", sel3, 3'b100);
        @(negedge clk);
        addr3[7:0] = 8'hC0;
        #1;
        $display("decode C0: sel=%b din=%h err=%b", sel3, mdin3, err3);
        check("dec_din_s2", mdin3, 32'h33333333);
        check("dec_err_map", err3, 1'b0);
        check("dec_sel_unmap", sel3, 3'b000);
        @(negedge clk);
        req3 = 2'b00;
        #1;
        check("dec_err_pulse", err3, 1'b1);
        check("dec_din_unmap", mdin3, 32'h0);
        @(negedge clk);
        #1;
        check("dec_err_clear", err3, 1'b0);

        // Asynchronous reset while master 1 owns the bus mid-write
        @(negedge clk);
        req2  = 2'b10;
        wr2   = 2'b10;
        addr2 = {8'h85, 8'h05};
        req3  = 2'b10;
        wr3   = 2'b10;
        addr3 = {8'hC0, 8'h00};
        @(negedge clk);
        #1;
        check("pre_rst_grant2", grant2, 2'b10);
        check("pre_rst_grant3", grant3, 2'b10);
        @(negedge clk);
        #1;
        check("pre_rst_err3", err3, 1'b1);
        check("pre_rst_din2", mdin2, 32'h5A5A5A5A);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: grant2=%b grant3=%b err3=%b din2=%h", grant2, grant3, err3, mdin2);
        check("rst_grant2", grant2, 2'b01);
        check("rst_grant3", grant3, 2'b01);
        check("rst_err3", err3, 1'b0);
        check("rst_din2", mdin2, 32'h0);
        req2 = '0;
        wr2  = '0;
        req3 = '0;
        wr3  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_grant2", grant2, 2'b01);
        check("post_rst_err3", err3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
